// File: rtl/controlador_cache_if.sv
// CPU-side and RAM-side signal bundle for the two-line cache controller.
// The controller takes the slave view; the environment takes the master view.
interface controlador_cache_if;
    logic       cpu_req;
    logic       cpu_write;
    logic [7:0] cpu_address;
    logic [7:0] cpu_dataIn;
    logic       cpu_ready;
    logic       cpu_done;
    logic [7:0] cpu_dataOut;
    logic       hit;
    logic       mem_req;
    logic       mem_write;
    logic [7:0] mem_address;
    logic [7:0] mem_dataOut;
    logic [7:0] mem_dataIn;
    logic       mem_ack;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    modport slave (
        input  cpu_req, cpu_write, cpu_address, cpu_dataIn, mem_dataIn, mem_ack,
        output cpu_ready, cpu_done, cpu_dataOut, hit, mem_req, mem_write,
               mem_address, mem_dataOut, hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_write, cpu_address, cpu_dataIn, mem_dataIn, mem_ack,
        input  cpu_ready, cpu_done, cpu_dataOut, hit, mem_req, mem_write,
               mem_address, mem_dataOut, hit_count, miss_count
    );
endinterface

// File: rtl/controlador_cache.sv
// Fully associative write-back, write-allocate cache controller with LRU victim
// selection, single-beat RAM handshake and saturating hit/miss counters.
module controlador_cache #(
    parameter int unsigned N_LINES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    controlador_cache_if.slave   bus
);
    localparam int unsigned WAY_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

    state_t             r_state;
    logic [N_LINES-1:0] r_valid;
    logic [N_LINES-1:0] r_dirty;
    logic [7:0]         r_tag  [N_LINES];
    logic [7:0]         r_data [N_LINES];
    logic [WAY_W-1:0]   r_lru;
    logic [WAY_W-1:0]   r_way;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;
    logic               r_write;

    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_free;

    // The line to evict next after touching way w: the following way, wrapping.
    function automatic logic [WAY_W-1:0] f_other(input logic [WAY_W-1:0] w);
        return (w == WAY_W'(N_LINES - 1)) ? '0 : w + WAY_W'(1);
    endfunction

    // Tag match and victim choice (lowest invalid line, otherwise LRU).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_free    = 1'b0;
        w_victim  = r_lru;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if (!w_hit && r_valid[i] && (r_tag[i] == r_addr)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!w_free && !r_valid[i]) begin
                w_free   = 1'b1;
                w_victim = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_valid         <= '0;
            r_dirty         <= '0;
            r_lru           <= '0;
            r_way           <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_write         <= 1'b0;
            for (int i = 0; i < int'(N_LINES); i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            bus.cpu_ready   <= 1'b1;
            bus.cpu_done    <= 1'b0;
            bus.cpu_dataOut <= '0;
            bus.hit         <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_dataOut <= '0;
            bus.hit_count   <= '0;
            bus.miss_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        r_addr        <= bus.cpu_address;
                        r_wdata       <= bus.cpu_dataIn;
                        r_write       <= bus.cpu_write;
                        bus.cpu_ready <= 1'b0;
                        r_state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_way   <= w_hit_way;
                        bus.hit <= 1'b1;
                        if (r_write) begin
                            r_data[w_hit_way]  <= r_wdata;
                            r_dirty[w_hit_way] <= 1'b1;
                            bus.cpu_dataOut    <= r_wdata;
                        end else begin
                            bus.cpu_dataOut    <= r_data[w_hit_way];
                        end
                        bus.cpu_done <= 1'b1;
                        r_state      <= RESPOND;
                    end else begin
                        r_way   <= w_victim;
                        bus.hit <= 1'b0;
                        if (r_valid[w_victim] && r_dirty[w_victim]) begin
                            bus.mem_req     <= 1'b1;
                            bus.mem_write   <= 1'b1;
                            bus.mem_address <= r_tag[w_victim];
                            bus.mem_dataOut <= r_data[w_victim];
                            r_state         <= WRITEBACK;
                        end else if (!r_write) begin
                            bus.mem_req     <= 1'b1;
                            bus.mem_write   <= 1'b0;
                            bus.mem_address <= r_addr;
                            r_state         <= FILL;
                        end else begin
                            // Write allocate without fetching the old contents.
                            r_tag[w_victim]   <= r_addr;
                            r_data[w_victim]  <= r_wdata;
                            r_valid[w_victim] <= 1'b1;
                            r_dirty[w_victim] <= 1'b1;
                            bus.cpu_dataOut   <= r_wdata;
                            bus.cpu_done      <= 1'b1;
                            r_state           <= RESPOND;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_req && bus.mem_ack) begin
                        r_dirty[r_way] <= 1'b0;
                        bus.mem_write  <= 1'b0;
                        if (!r_write) begin
                            bus.mem_address <= r_addr;
                            r_state         <= FILL;
                        end else begin
                            bus.mem_req     <= 1'b0;
                            r_tag[r_way]    <= r_addr;
                            r_data[r_way]   <= r_wdata;
                            r_valid[r_way]  <= 1'b1;
                            r_dirty[r_way]  <= 1'b1;
                            bus.cpu_dataOut <= r_wdata;
                            bus.cpu_done    <= 1'b1;
                            r_state         <= RESPOND;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_req && bus.mem_ack) begin
                        bus.mem_req     <= 1'b0;
                        r_tag[r_way]    <= r_addr;
                        r_data[r_way]   <= bus.mem_dataIn;
                        r_valid[r_way]  <= 1'b1;
                        r_dirty[r_way]  <= 1'b0;
                        bus.cpu_dataOut <= bus.mem_dataIn;
                        bus.cpu_done    <= 1'b1;
                        r_state         <= RESPOND;
                    end
                end
                RESPOND: begin
                    bus.cpu_done  <= 1'b0;
                    bus.cpu_ready <= 1'b1;
                    r_lru         <= f_other(r_way);
                    if (bus.hit) begin
                        if (bus.hit_count != 8'hFF) bus.hit_count <= bus.hit_count + 8'd1;
                    end else begin
                        if (bus.miss_count != 8'hFF) bus.miss_count <= bus.miss_count + 8'd1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_cache.sv
// Directed bench for controlador_cache: table of CPU accesses with hand-computed
// RAM traffic and results, plus sequences for stalls, reset and saturation.
module tb_controlador_cache;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    controlador_cache_if bus();

    controlador_cache #(.N_LINES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic       e_hit;
        logic [7:0] e_dout;
        int         e_wb;
        logic [7:0] e_wb_a;
        logic [7:0] e_wb_d;
        int         e_fill;
        logic [7:0] e_fill_a;
        int         e_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!bus.cpu_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!bus.cpu_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got cpu_ready=0 expected 1");
        end
    endtask

    // Issues one access and plays a RAM that acknowledges each request at once.
    task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] rd, output logic g_hit,
                             output logic [7:0] g_dout, output int n_wb,
                             output logic [7:0] wb_a, output logic [7:0] wb_d,
                             output int n_fill, output logic [7:0] fill_a,
                             output int lat);
        bit done;
        n_wb = 0; n_fill = 0; wb_a = '0; wb_d = '0; fill_a = '0;
        g_hit = 1'b0; g_dout = '0; done = 1'b0;
        wait_ready();
        bus.cpu_req = 1'b1; bus.cpu_write = w; bus.cpu_address = a; bus.cpu_dataIn = d;
        tick();
        bus.cpu_req = 1'b0;
        lat = 1;
        while (!done && lat < 50) begin
            if (bus.cpu_done) begin
                done   = 1'b1;
                g_hit  = bus.hit;
                g_dout = bus.cpu_dataOut;
            end else begin
                if (bus.mem_req) begin
                    if (bus.mem_write) begin
                        n_wb++;
                        wb_a = bus.mem_address;
                        wb_d = bus.mem_dataOut;
                    end else begin
                        n_fill++;
                        fill_a = bus.mem_address;
                        bus.mem_dataIn = rd;
                    end
                    bus.mem_ack = 1'b1;
                end
                tick();
                bus.mem_ack = 1'b0;
                lat++;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no cpu_done expected a pulse within 50 cycles");
        end
    endtask

    logic       g_hit;
    logic [7:0] g_dout, wb_a, wb_d, fill_a;
    int         n_wb, n_fill, lat;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_dataIn = '0;
        bus.mem_dataIn = '0; bus.mem_ack = 1'b0;

        //           w     addr   wdata  ram    hit   dout   wb wb_a   wb_d   f  fill_a lat
        vecs[0] = '{1'b0, 8'h64, 8'h00, 8'h05, 1'b0, 8'h05, 0, 8'h00, 8'h00, 1, 8'h64, 3};
        vecs[1] = '{1'b0, 8'h64, 8'h00, 8'hEE, 1'b1, 8'h05, 0, 8'h00, 8'h00, 0, 8'h00, 2};
        vecs[2] = '{1'b1, 8'h65, 8'h03, 8'hEE, 1'b0, 8'h03, 0, 8'h00, 8'h00, 0, 8'h00, 2};
        vecs[3] = '{1'b1, 8'h64, 8'h07, 8'hEE, 1'b1, 8'h07, 0, 8'h00, 8'h00, 0, 8'h00, 2};
        vecs[4] = '{1'b0, 8'h66, 8'h00, 8'h11, 1'b0, 8'h11, 1, 8'h65, 8'h03, 1, 8'h66, 4};
        vecs[5] = '{1'b0, 8'h64, 8'h00, 8'hEE, 1'b1, 8'h07, 0, 8'h00, 8'h00, 0, 8'h00, 2};
        vecs[6] = '{1'b0, 8'h65, 8'h00, 8'h03, 1'b0, 8'h03, 0, 8'h00, 8'h00, 1, 8'h65, 3};
        vecs[7] = '{1'b1, 8'h70, 8'hAA, 8'hEE, 1'b0, 8'hAA, 1, 8'h64, 8'h07, 0, 8'h00, 3};
        vecs[8] = '{1'b0, 8'h70, 8'h00, 8'hEE, 1'b1, 8'hAA, 0, 8'h00, 8'h00, 0, 8'h00, 2};
        vecs[9] = '{1'b0, 8'h65, 8'h00, 8'hEE, 1'b1, 8'h03, 0, 8'h00, 8'h00, 0, 8'h00, 2};

        tick();
        tick();
        check("rst_ready",   32'(bus.cpu_ready),   32'd1);
        check("rst_done",    32'(bus.cpu_done),    32'd0);
        check("rst_memreq",  32'(bus.mem_req),     32'd0);
        check("rst_memwr",   32'(bus.mem_write),   32'd0);
        check("rst_hit",     32'(bus.hit),         32'd0);
        check("rst_dout",    32'(bus.cpu_dataOut), 32'd0);
        check("rst_maddr",   32'(bus.mem_address), 32'd0);
        check("rst_mdout",   32'(bus.mem_dataOut), 32'd0);
        check("rst_hits",    32'(bus.hit_count),   32'd0);
        check("rst_misses",  32'(bus.miss_count),  32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd,
                      g_hit, g_dout, n_wb, wb_a, wb_d, n_fill, fill_a, lat);
            check($sformatf("v%0d_hit", i),   32'(g_hit),   32'(vecs[i].e_hit));
            check($sformatf("v%0d_dout", i),  32'(g_dout),  32'(vecs[i].e_dout));
            check($sformatf("v%0d_nwb", i),   32'(n_wb),    32'(vecs[i].e_wb));
            check($sformatf("v%0d_nfill", i), 32'(n_fill),  32'(vecs[i].e_fill));
            check($sformatf("v%0d_lat", i),   32'(lat),     32'(vecs[i].e_lat));
            if (vecs[i].e_wb > 0) begin
                check($sformatf("v%0d_wb_addr", i), 32'(wb_a), 32'(vecs[i].e_wb_a));
                check($sformatf("v%0d_wb_data", i), 32'(wb_d), 32'(vecs[i].e_wb_d));
            end
            if (vecs[i].e_fill > 0)
                check($sformatf("v%0d_fill_addr", i), 32'(fill_a), 32'(vecs[i].e_fill_a));
        end
        tick();
        check("tbl_hits",   32'(bus.hit_count),  32'd5);
        check("tbl_misses", 32'(bus.miss_count), 32'd5);

        // Read 0x90 evicts dirty line 0x70; reset lands in the write-back.
        wait_ready();
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_address = 8'h90;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        check("wb_memreq",  32'(bus.mem_req),     32'd1);
        check("wb_memwr",   32'(bus.mem_write),   32'd1);
        check("wb_addr",    32'(bus.mem_address), 32'h70);
        check("wb_data",    32'(bus.mem_dataOut), 32'hAA);
        reset = 1'b1;
        #1;
        check("arst_memreq", 32'(bus.mem_req),    32'd0);
        check("arst_memwr",  32'(bus.mem_write),  32'd0);
        check("arst_ready",  32'(bus.cpu_ready),  32'd1);
        check("arst_misses", 32'(bus.miss_count), 32'd0);
        tick();
        check("arst_done",   32'(bus.cpu_done),   32'd0);
        reset = 1'b0;
        tick();
        do_access(1'b0, 8'h70, 8'h00, 8'h22, g_hit, g_dout, n_wb, wb_a, wb_d, n_fill, fill_a, lat);
        check("post_rst_hit",  32'(g_hit),  32'd0);
        check("post_rst_nwb",  32'(n_wb),   32'd0);
        check("post_rst_dout", 32'(g_dout), 32'h22);
        do_access(1'b0, 8'h65, 8'h00, 8'h44, g_hit, g_dout, n_wb, wb_a, wb_d, n_fill, fill_a, lat);
        check("post_rst2_hit", 32'(g_hit),  32'd0);
        check("post_rst2_fill", 32'(fill_a), 32'h65);

        // Fill of 0x50 with the RAM stalling and the CPU hammering cpu_req.
        wait_ready();
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_address = 8'h50;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.cpu_req = 1'b1; bus.cpu_write = 1'b1;
            bus.cpu_address = 8'h65; bus.cpu_dataIn = 8'hEE;
            tick();
            check($sformatf("stall%0d_memreq", k), 32'(bus.mem_req),     32'd1);
            check($sformatf("stall%0d_memwr", k),  32'(bus.mem_write),   32'd0);
            check($sformatf("stall%0d_addr", k),   32'(bus.mem_address), 32'h50);
            check($sformatf("stall%0d_ready", k),  32'(bus.cpu_ready),   32'd0);
            check($sformatf("stall%0d_done", k),   32'(bus.cpu_done),    32'd0);
        end
        bus.cpu_req = 1'b0;
        bus.mem_dataIn = 8'h5A;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("stall_done",   32'(bus.cpu_done),    32'd1);
        check("stall_dout",   32'(bus.cpu_dataOut), 32'h5A);
        check("stall_hit",    32'(bus.hit),         32'd0);
        check("stall_memreq", 32'(bus.mem_req),     32'd0);
        tick();
        check("pulse_len",    32'(bus.cpu_done),    32'd0);
        check("back_ready",   32'(bus.cpu_ready),   32'd1);
        do_access(1'b0, 8'h65, 8'h00, 8'h00, g_hit, g_dout, n_wb, wb_a, wb_d, n_fill, fill_a, lat);
        check("ignored_hit",  32'(g_hit),  32'd1);
        check("ignored_dout", 32'(g_dout), 32'h44);

        // Hit counter saturation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_access(1'b0, 8'h10, 8'h00, 8'h99, g_hit, g_dout, n_wb, wb_a, wb_d, n_fill, fill_a, lat);
        for (int k = 0; k < 300; k++)
            do_access(1'b0, 8'h10, 8'h00, 8'h00, g_hit, g_dout, n_wb, wb_a, wb_d, n_fill, fill_a, lat);
        check("sat_last_hit", 32'(g_hit),  32'd1);
        check("sat_last_dout", 32'(g_dout), 32'h99);
        tick();
        check("sat_hits",   32'(bus.hit_count),  32'd255);
        check("sat_misses", 32'(bus.miss_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
